// File: rtl/instr_pkg.sv
// Shared defaults and layout constants for the instruction word and queue sizing.
package instr_pkg;

    localparam int OP_W_DEF  = 6;
    localparam int REG_W_DEF = 5;
    localparam int IMM_W_DEF = 16;
    localparam int WIDTH_DEF = OP_W_DEF + 2 * REG_W_DEF + IMM_W_DEF;

    // Default field layout: opcode on top, rs then rt below it, immediate at the bottom.
    localparam int OP_LSB_DEF  = WIDTH_DEF - OP_W_DEF;
    localparam int RS_LSB_DEF  = OP_LSB_DEF - REG_W_DEF;
    localparam int RT_LSB_DEF  = RS_LSB_DEF - REG_W_DEF;
    localparam int IMM_LSB_DEF = 0;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Splits an instruction word into opcode, register specifiers and immediate.
// All outputs read zero when the word is not valid.
module instr_field_decode
    import instr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OP_W  = OP_W_DEF,
    parameter int REG_W = REG_W_DEF,
    parameter int IMM_W = IMM_W_DEF
) (
    input  logic [WIDTH-1:0] word,
    input  logic             valid,
    input  logic             sext,
    output logic [OP_W-1:0]  op_out,
    output logic [REG_W-1:0] reg1,
    output logic [REG_W-1:0] reg2,
    output logic [IMM_W-1:0] imm,
    output logic [WIDTH-1:0] imm_ext
);

    localparam int OP_LSB = WIDTH - OP_W;
    localparam int RS_LSB = OP_LSB - REG_W;
    localparam int RT_LSB = RS_LSB - REG_W;

    if (WIDTH != OP_W + 2 * REG_W + IMM_W) begin : g_bad_layout
        $error("instr_field_decode: WIDTH must equal OP_W + 2*REG_W + IMM_W");
    end

    always_comb begin
        op_out  = '0;
        reg1    = '0;
        reg2    = '0;
        imm     = '0;
        imm_ext = '0;
        if (valid) begin
            op_out  = word[OP_LSB +: OP_W];
            reg1    = word[RS_LSB +: REG_W];
            reg2    = word[RT_LSB +: REG_W];
            imm     = word[IMM_W-1:0];
            imm_ext = {{(WIDTH - IMM_W){sext & word[IMM_W-1]}}, word[IMM_W-1:0]};
        end
    end

endmodule

// File: rtl/instr_queue.sv
// FIFO of fetched instruction words between instruction memory and the control FSM;
// the head entry is presented pre-decoded into its fields.
module instr_queue
    import instr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4,
    parameter int OP_W  = OP_W_DEF,
    parameter int REG_W = REG_W_DEF,
    parameter int IMM_W = IMM_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_instr,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OP_W-1:0]               op_out,
    output logic [REG_W-1:0]              reg1,
    output logic [REG_W-1:0]              reg2,
    output logic [IMM_W-1:0]              imm,
    input  logic                          sext,
    output logic [WIDTH-1:0]              imm_ext,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic             push;
    logic             pop;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready drops in reset, flush and when full (no pass-through even with a pop);
    // a pop is ignored in a flush cycle, and out_ready is ignored while empty.
    assign in_ready  = !reset && !flush && (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: entries are only visible once count says they are.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= in_instr;
    end

    instr_field_decode #(
        .WIDTH(WIDTH),
        .OP_W (OP_W),
        .REG_W(REG_W),
        .IMM_W(IMM_W)
    ) u_decode (
        .word   (mem[rp]),
        .valid  (out_valid),
        .sext   (sext),
        .op_out (op_out),
        .reg1   (reg1),
        .reg2   (reg2),
        .imm    (imm),
        .imm_ext(imm_ext)
    );

endmodule
